usb2_ulpi_link: RTL and testbench

USB2_ULPI_LINK -- requirements
Module: usb2_ulpi_link

---
 rtl/usb2_ulpi_pkg.sv | 33 +++
 rtl/usb2_ulpi_link.sv | 164 ++++++++++++++++
 tb/tb_usb2_ulpi_link.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb2_ulpi_pkg.sv
// Shared ULPI link definitions: FSM encoding, RX CMD field positions, TX CMD
// prefixes and the Function Control register values used at power-up.
package usb2_ulpi_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_INIT_CMD,
    ST_INIT_DATA,
    ST_INIT_STP,
    ST_IDLE,
    ST_RX,
    ST_TX,
    ST_TX_STP
  } ulpi_state_e;

  // RX CMD byte layout
  localparam int RXCMD_LS_LSB  = 0;
  localparam int RXCMD_ACT_BIT = 4;
  localparam int RXCMD_ERR_BIT = 5;

  localparam logic [7:0] TXCMD_TRANSMIT = 8'h40;
  localparam logic [7:0] TXCMD_REGWR    = 8'h80;

  localparam logic [5:0] FUNC_CTRL_ADDR = 6'h04;
  localparam logic [7:0] FUNC_CTRL_INIT = 8'h40;

  localparam int PWRUP_CYCLES = 8;

  function automatic logic [7:0] regwr_cmd(input logic [5:0] addr);
    return TXCMD_REGWR | {2'b00, addr};
  endfunction

endpackage

// File: rtl/usb2_ulpi_link.sv
// ULPI link-side bus controller: RX CMD / data decode, packet transmit and
// optional Function Control write at power-up (USB2_ULPI_INIT_REGWR_EN).
module usb2_ulpi_link
  import usb2_ulpi_pkg::*;
(
  input  logic       phy_clk,
  input  logic       reset_n,
  input  logic       ulpi_dir,
  input  logic       ulpi_nxt,
  input  logic [7:0] ulpi_data_in,
  output logic [7:0] ulpi_data_out,
  output logic       ulpi_data_oe,
  output logic       ulpi_stp,
  output logic       in_act,
  output logic [7:0] in_byte,
  output logic       in_latch,
  output logic       out_cts,
  output logic       out_nxt,
  input  logic [7:0] out_byte,
  input  logic       out_latch,
  input  logic       out_stp,
  output logic [1:0] line_state,
  output logic       rx_err,
  output logic       tx_abort
);

  ulpi_state_e state, nstate;
  logic [2:0]  pwr_cnt;
  logic        dir_q;
  logic        latch_q;

  // Bus data is meaningless during the turnaround cycle in either direction.
  logic turn, rx_cmd, rx_dat, bus_free, latch_rise, pwr_done;
  assign turn       = ulpi_dir ^ dir_q;
  assign rx_cmd     = ulpi_dir & ~turn & ~ulpi_nxt;
  assign rx_dat     = ulpi_dir & ~turn & ulpi_nxt;
  assign bus_free   = ~ulpi_dir & ~dir_q;
  assign latch_rise = out_latch & ~latch_q;
  assign pwr_done   = ~ulpi_dir & (pwr_cnt == 3'(PWRUP_CYCLES - 1));

  logic       err_cmd;
  assign err_cmd = ulpi_data_in[RXCMD_ERR_BIT] & ulpi_data_in[RXCMD_ACT_BIT];

  always_ff @(posedge phy_clk or negedge reset_n) begin
    if (!reset_n) begin
      dir_q      <= 1'b0;
      latch_q    <= 1'b0;
      in_act     <= 1'b0;
      in_byte    <= 8'h00;
      in_latch   <= 1'b0;
      line_state <= 2'b00;
      rx_err     <= 1'b0;
    end else begin
      dir_q    <= ulpi_dir;
      latch_q  <= out_latch;
      in_latch <= 1'b0;
      if (rx_cmd) begin
        line_state <= ulpi_data_in[RXCMD_LS_LSB +: 2];
        in_act     <= ulpi_data_in[RXCMD_ACT_BIT];
        // sticky error, re-armed on each new RxActive rise
        if (err_cmd)
          rx_err <= 1'b1;
        else if (ulpi_data_in[RXCMD_ACT_BIT] && !in_act)
          rx_err <= 1'b0;
      end else if (rx_dat && in_act) begin
        in_byte  <= ulpi_data_in;
        in_latch <= 1'b1;
      end else if (dir_q && !ulpi_dir) begin
        in_act <= 1'b0;
      end
    end
  end

  always_ff @(posedge phy_clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_PWRUP;
      pwr_cnt <= 3'd0;
    end else begin
      state <= nstate;
      if (state != ST_PWRUP || ulpi_dir || pwr_done)
        pwr_cnt <= 3'd0;
      else
        pwr_cnt <= pwr_cnt + 3'd1;
    end
  end

  always_comb begin
    nstate        = state;
    ulpi_data_out = 8'h00;
    ulpi_data_oe  = 1'b0;
    ulpi_stp      = 1'b0;
    out_cts       = 1'b0;
    out_nxt       = 1'b0;
    tx_abort      = 1'b0;
    case (state)
      ST_PWRUP: begin
`ifdef USB2_ULPI_INIT_REGWR_EN
        if (pwr_done) nstate = ST_INIT_CMD;
`else
        if (pwr_done) nstate = ST_IDLE;
`endif
      end
`ifdef USB2_ULPI_INIT_REGWR_EN
      // Wait out any PHY ownership here; the write restarts from the command.
      ST_INIT_CMD: begin
        if (bus_free) begin
          ulpi_data_oe  = 1'b1;
          ulpi_data_out = regwr_cmd(FUNC_CTRL_ADDR);
          if (ulpi_nxt) nstate = ST_INIT_DATA;
        end
      end
      ST_INIT_DATA: begin
        if (ulpi_dir) nstate = ST_INIT_CMD;
        else begin
          ulpi_data_oe  = 1'b1;
          ulpi_data_out = FUNC_CTRL_INIT;
          if (ulpi_nxt) nstate = ST_INIT_STP;
        end
      end
      ST_INIT_STP: begin
        if (ulpi_dir) nstate = ST_INIT_CMD;
        else begin
          ulpi_data_oe = 1'b1;
          ulpi_stp     = 1'b1;
          nstate       = ST_IDLE;
        end
      end
`endif
      ST_IDLE: begin
        out_cts = bus_free & ~in_act;
        if (ulpi_dir)
          nstate = ST_RX;
        else if (latch_rise && out_cts)
          nstate = ST_TX;
      end
      ST_RX: begin
        if (!ulpi_dir) nstate = ST_IDLE;
      end
      ST_TX: begin
        ulpi_data_out = out_byte;
        out_nxt       = ulpi_nxt;
        if (ulpi_dir) begin
          tx_abort = 1'b1;
          nstate   = ST_RX;
        end else begin
          ulpi_data_oe = 1'b1;
          if (out_stp) nstate = ST_TX_STP;
        end
      end
      ST_TX_STP: begin
        if (ulpi_dir) begin
          tx_abort = 1'b1;
          nstate   = ST_RX;
        end else begin
          ulpi_data_oe = 1'b1;
          ulpi_stp     = 1'b1;
          nstate       = ST_IDLE;
        end
      end
      default: nstate = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_usb2_ulpi_link.sv
// Directed + randomized bench for usb2_ulpi_link with a packet-level model of
// RX CMD state (RxActive, LineState, sticky error) and TX byte handshakes.
module tb_usb2_ulpi_link;

  logic       phy_clk = 1'b0;
  logic       reset_n;
  logic       ulpi_dir, ulpi_nxt;
  logic [7:0] ulpi_data_in, ulpi_data_out;
  logic       ulpi_data_oe, ulpi_stp;
  logic       in_act, in_latch, out_cts, out_nxt;
  logic [7:0] in_byte, out_byte;
  logic       out_latch, out_stp;
  logic [1:0] line_state;
  logic       rx_err, tx_abort;

  usb2_ulpi_link dut (
    .phy_clk(phy_clk), .reset_n(reset_n),
    .ulpi_dir(ulpi_dir), .ulpi_nxt(ulpi_nxt), .ulpi_data_in(ulpi_data_in),
    .ulpi_data_out(ulpi_data_out), .ulpi_data_oe(ulpi_data_oe), .ulpi_stp(ulpi_stp),
    .in_act(in_act), .in_byte(in_byte), .in_latch(in_latch),
    .out_cts(out_cts), .out_nxt(out_nxt), .out_byte(out_byte),
    .out_latch(out_latch), .out_stp(out_stp),
    .line_state(line_state), .rx_err(rx_err), .tx_abort(tx_abort)
  );

  always #8 phy_clk = ~phy_clk;

  int tests = 0;
  int fails = 0;

  // reference model of RX CMD derived state
  logic       exp_act;
  logic [1:0] exp_ls;
  logic       exp_err;
  logic [7:0] fix_q[$];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set(input logic d, input logic n, input logic [7:0] dat);
    ulpi_dir = d; ulpi_nxt = n; ulpi_data_in = dat;
    #1;
  endtask

  task automatic clk();
    @(posedge phy_clk);
    @(negedge phy_clk);
  endtask

  // Link leaves power-up once dir has been low for 8 consecutive edges.
  task automatic pwrup(input int glitch_at);
    int run = 0;
    for (int c = 0; c < 40 && run < 8; c++) begin
      logic d;
      d = (c == glitch_at);
      set(d, 1'b0, 8'($urandom));
      chk("pwrup_cts", out_cts, 0);
      chk("pwrup_oe", ulpi_data_oe, 0);
      clk();
      run = d ? 0 : run + 1;
    end
`ifdef USB2_ULPI_INIT_REGWR_EN
    set(0, 0, 8'h00);
    chk("init_cmd", ulpi_data_out, 8'h84);
    chk("init_cmd_oe", ulpi_data_oe, 1);
    clk();
    chk("init_cmd_hold", ulpi_data_out, 8'h84);
    set(0, 1, 8'h00);
    clk();
    chk("init_data", ulpi_data_out, 8'h40);
    set(0, 1, 8'h00);
    clk();
    set(0, 0, 8'h00);
    chk("init_stp", ulpi_stp, 1);
    chk("init_stp_data", ulpi_data_out, 8'h00);
    clk();
`endif
    set(0, 0, 8'h00);
    chk("idle_cts", out_cts, 1);
    chk("idle_stp", ulpi_stp, 0);
    chk("idle_oe", ulpi_data_oe, 0);
  endtask

  // One receive: [turnaround] RX CMD, n bytes (optionally interleaved RX CMDs), dir drop.
  task automatic rx_pkt(input int n, input logic err, input logic mid, input logic skip_ta);
    logic [1:0] ls;
    logic [7:0] b;
    if (!skip_ta) begin
      set(1, 0, 8'($urandom));
      chk("rx_ta_oe", ulpi_data_oe, 0);
      clk();
      chk("rx_ta_ls", line_state, exp_ls);
      chk("rx_ta_latch", in_latch, 0);
    end
    ls = mid ? 2'($urandom) : 2'b00;
    set(1, 0, {2'b00, err, 1'b1, 2'b00, ls});
    clk();
    if (!exp_act) exp_err = err; else if (err) exp_err = 1'b1;
    exp_act = 1'b1; exp_ls = ls;
    chk("rx_act", in_act, exp_act);
    chk("rx_ls", line_state, exp_ls);
    chk("rx_err", rx_err, exp_err);
    for (int i = 0; i < n; i++) begin
      if (mid && $urandom_range(0, 3) == 0) begin
        logic e;
        e = ($urandom_range(0, 7) == 0);
        ls = 2'($urandom);
        set(1, 0, {2'b00, e, 1'b1, 2'b00, ls});
        clk();
        exp_ls = ls;
        if (e) exp_err = 1'b1;
        chk("rx_mid_latch", in_latch, 0);
        chk("rx_mid_ls", line_state, exp_ls);
        chk("rx_mid_err", rx_err, exp_err);
      end
      b = (i < fix_q.size()) ? fix_q[i] : 8'($urandom);
      set(1, 1, b);
      chk("rx_dat_oe", ulpi_data_oe, 0);
      clk();
      chk("rx_latch", in_latch, 1);
      chk("rx_byte", in_byte, b);
      chk("rx_act_hold", in_act, 1);
    end
    set(0, 0, 8'($urandom));
    clk();
    exp_act = 1'b0;
    chk("rx_end_act", in_act, exp_act);
    chk("rx_end_latch", in_latch, 0);
    chk("rx_end_err", rx_err, exp_err);
    chk("rx_end_cts", out_cts, 1);
    fix_q.delete();
  endtask

  // One transmit of n bytes; abort_at = byte index (n => during stop cycle), -1 none.
  task automatic tx_pkt(input int n, input logic [7:0] b0, input int wfix, input int abort_at);
    logic [7:0] b;
    int w;
    chk("tx_pre_cts", out_cts, 1);
    out_latch = 1'b1; out_byte = b0; out_stp = 1'b0;
    set(0, 0, 8'h00);
    chk("tx_pre_oe", ulpi_data_oe, 0);
    clk();
    for (int i = 0; i < n; i++) begin
      b = (i == 0) ? b0 : 8'($urandom);
      out_byte = b;
      if (abort_at == i) begin
        set(1, 0, 8'($urandom));
        chk("abort_oe", ulpi_data_oe, 0);
        chk("abort_pulse", tx_abort, 1);
        out_latch = 1'b0;
        clk();
        chk("abort_pulse_end", tx_abort, 0);
        chk("abort_oe_after", ulpi_data_oe, 0);
        return;
      end
      w = (wfix >= 0) ? wfix : $urandom_range(0, 2);
      repeat (w) begin
        set(0, 0, 8'($urandom));
        chk("tx_hold_oe", ulpi_data_oe, 1);
        chk("tx_hold_data", ulpi_data_out, b);
        chk("tx_hold_nxt", out_nxt, 0);
        chk("tx_hold_stp", ulpi_stp, 0);
        clk();
      end
      out_stp = (i == n - 1);
      set(0, 1, 8'($urandom));
      chk("tx_acc_data", ulpi_data_out, b);
      chk("tx_acc_nxt", out_nxt, 1);
      chk("tx_acc_oe", ulpi_data_oe, 1);
      clk();
    end
    out_stp = 1'b0; out_latch = 1'b0;
    if (abort_at == n) begin
      set(1, 0, 8'($urandom));
      chk("abort_stp_oe", ulpi_data_oe, 0);
      chk("abort_stp_stp", ulpi_stp, 0);
      chk("abort_stp_pulse", tx_abort, 1);
      clk();
      return;
    end
    set(0, 0, 8'($urandom));
    chk("tx_stp", ulpi_stp, 1);
    chk("tx_stp_data", ulpi_data_out, 8'h00);
    chk("tx_stp_oe", ulpi_data_oe, 1);
    chk("tx_stp_cts", out_cts, 0);
    clk();
    chk("tx_end_stp", ulpi_stp, 0);
    chk("tx_end_oe", ulpi_data_oe, 0);
    chk("tx_end_cts", out_cts, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_act = 1'b0; exp_ls = 2'b00; exp_err = 1'b0;
    reset_n = 1'b0; out_latch = 1'b0; out_stp = 1'b0; out_byte = 8'h00;
    set(0, 0, 8'h00);
    clk(); clk();
    chk("rst_oe", ulpi_data_oe, 0);
    chk("rst_stp", ulpi_stp, 0);
    chk("rst_data", ulpi_data_out, 8'h00);
    chk("rst_ls", line_state, 2'b00);
    chk("rst_act", in_act, 0);
    chk("rst_err", rx_err, 0);
    chk("rst_cts", out_cts, 0);
    chk("rst_latch", in_latch, 0);
    reset_n = 1'b1;
    pwrup(-1);

    fix_q = '{8'hC3, 8'h01, 8'h02};
    rx_pkt(3, 1'b0, 1'b0, 1'b0);
    rx_pkt(0, 1'b1, 1'b0, 1'b0);
    rx_pkt(0, 1'b0, 1'b0, 1'b0);
    tx_pkt(1, 8'h4D, 2, -1);
    tx_pkt(3, 8'h41, -1, 1);
    rx_pkt(2, 1'b0, 1'b0, 1'b1);
    tx_pkt(1, 8'h42, 0, 1);
    rx_pkt(0, 1'b0, 1'b0, 1'b1);

    // out_latch rising while the PHY owns the bus must not start a transmit
    out_latch = 1'b1; out_byte = 8'h43;
    set(1, 0, 8'h00); clk();
    set(1, 0, 8'h10); clk();
    set(0, 0, 8'h00); clk();
    exp_act = 1'b0; exp_ls = 2'b00; exp_err = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set(0, 0, 8'h00);
      chk("late_latch_oe", ulpi_data_oe, 0);
      clk();
    end
    out_latch = 1'b0;
    set(0, 0, 8'h00); clk();

    for (int k = 0; k < 8; k++) begin
      if ($urandom_range(0, 1) == 1)
        rx_pkt($urandom_range(1, 8), ($urandom_range(0, 3) == 0), 1'b1, 1'b0);
      else
        tx_pkt($urandom_range(1, 6), 8'h40 | 8'($urandom_range(0, 15)), -1, -1);
    end

    // asynchronous reset in the middle of a transmit
    out_latch = 1'b1; out_byte = 8'h4D;
    set(0, 0, 8'h00); clk();
    chk("mid_tx_oe", ulpi_data_oe, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_tx_oe", ulpi_data_oe, 0);
    chk("rst_tx_stp", ulpi_stp, 0);
    chk("rst_tx_data", ulpi_data_out, 8'h00);
    out_latch = 1'b0;
    @(negedge phy_clk);
    reset_n = 1'b1;
    exp_act = 1'b0; exp_ls = 2'b00; exp_err = 1'b0;
    pwrup(4);
    tx_pkt(2, 8'h4B, -1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
